// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
// Contents: FSM state enum, SPI frame geometry, request payload struct and a
// helper that builds a write frame from a request.
package spi_cfg_pkg;

  localparam int unsigned SPI_FRAME_W   = 16;
  localparam int unsigned SPI_WRITE_BIT = 15;
  localparam int unsigned ADDR_W        = 7;
  localparam int unsigned DATA_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Buffered register-write request, addr in the upper bits.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_req_t;

  // Write frame: write flag in the MSB, then addr, then data.
  function automatic logic [SPI_FRAME_W-1:0] make_frame(cfg_req_t r);
    logic [SPI_FRAME_W-1:0] f;
    f = {1'b0, r};
    f[SPI_WRITE_BIT] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Request/status interface of the SPI configuration sequencer.
// Signals: req_valid/req_ready handshake with req_addr/req_data payload,
// busy level, done and err pulses. master = requester, slave = sequencer.
interface spi_cfg_if;
  import spi_cfg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done, err
  );

endinterface

// File: rtl/spi_cfg_sequencer_fifo.sv
// Synchronous request FIFO with wrap-bit pointers for full/empty detection.
// Ports: clk, rst_n (async active-low), push/din write side, pop/dout read
// side (dout shows the head combinationally), full, empty.
module cfg_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bits means the write side lapped the read side.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// SPI controller that serialises buffered register writes to a slow SPI
// peripheral as 16-bit mode-0 write frames, MSB first.
// Ports: clk, rst_n (async active-low), req (spi_cfg_if.slave: request
// handshake, busy, done, err), SCLK/COPI/nCS SPI pins.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 8,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_ADDR   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_cfg_if.slave   req,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int unsigned HALF2   = 2 * CLK_DIV;
  localparam int unsigned TMR_A   = (CS_SETUP > HALF2) ? CS_SETUP : HALF2;
  localparam int unsigned TMR_MAX = (TMR_A > GAP_CYCLES) ? TMR_A : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned BIT_W   = $clog2(SPI_FRAME_W);
  localparam int unsigned REQ_W   = $bits(cfg_req_t);

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [SPI_FRAME_W-1:0] sr_q, sr_d;
  logic                   sclk_q, sclk_d;
  logic                   copi_q, copi_d;
  logic                   ncs_q, ncs_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   addr_bad;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  cfg_req_t               fifo_din;
  cfg_req_t               fifo_dout;

  // Out-of-range requests are consumed but never buffered.
  assign accept    = req.req_valid && !fifo_full;
  assign addr_bad  = req.req_addr > ADDR_W'(MAX_ADDR);
  assign fifo_push = accept && !addr_bad;
  assign fifo_din  = {req.req_addr, req.req_data};

  cfg_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counters, shift register and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sr_d     = make_frame(fifo_dout);
          bit_d    = BIT_W'(SPI_FRAME_W - 1);
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == TMR_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      ST_SHIFT: begin
        // cnt counts one SCLK period; the next bit is presented as SCLK falls.
        if (cnt_q == TMR_W'(HALF2 - 1)) begin
          cnt_d = '0;
          sr_d  = {sr_q[SPI_FRAME_W-2:0], 1'b0};
          bit_d = bit_q - BIT_W'(1);
          if (bit_q == '0) state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == TMR_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == TMR_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMR_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register alongside it.
    ncs_d  = !(state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    sclk_d = (state_d == ST_SHIFT) && (cnt_d >= TMR_W'(CLK_DIV));
    copi_d = ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) &&
             sr_d[SPI_FRAME_W-1];
    done_d = (state_q == ST_HOLD) && (state_d == ST_GAP);
    err_d  = accept && addr_bad;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign SCLK          = sclk_q;
  assign COPI          = copi_q;
  assign nCS           = ncs_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign req.req_ready = !fifo_full;
  assign req.busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer: per-cycle comparison against a
// frame-timeline reference model, an SPI peripheral decoder, directed
// scenarios with literal expectations, then randomized traffic.
module tb_spi_cfg_sequencer;

  localparam int CLK_DIV    = 4;
  localparam int CS_SETUP   = 8;
  localparam int GAP_CYCLES = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_ADDR   = 4;
  localparam int SHIFT_LEN  = 32 * CLK_DIV;
  localparam int LOW        = CS_SETUP + SHIFT_LEN + CLK_DIV;
  localparam int WAIT_MAX   = 4000;

  logic clk;
  logic rst_n;
  logic sclk, copi, ncs;

  spi_cfg_if ifc ();

  spi_cfg_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .CS_SETUP   (CS_SETUP),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_ADDR   (MAX_ADDR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (ifc),
    .SCLK  (sclk),
    .COPI  (copi),
    .nCS   (ncs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending frames plus cycles elapsed since the
  // current frame was taken from the queue.
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  bit          m_active;
  int          m_off;
  bit          m_err;
  bit [7:0]    exp_reg [128];

  initial begin
    int  n_pre;
    bit  acc;
    m_active = 0; m_off = 0; m_err = 0; m_cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_active = 0; m_off = 0; m_err = 0;
      end else begin
        n_pre = m_q.size();
        acc   = ifc.req_valid && (n_pre < FIFO_DEPTH);
        if (m_active) begin
          m_off++;
          if (m_off == LOW + 1) exp_reg[m_cur[14:8]] = m_cur[7:0];
          if (m_off == LOW + GAP_CYCLES + 1) m_active = 0;
        end else if (n_pre > 0) begin
          m_cur = m_q.pop_front();
          m_active = 1;
          m_off = 1;
        end
        m_err = acc && (int'(ifc.req_addr) > MAX_ADDR);
        if (acc && int'(ifc.req_addr) <= MAX_ADDR)
          m_q.push_back({1'b1, ifc.req_addr, ifc.req_data});
      end
    end
  end

  // Peripheral side: sample COPI on SCLK rising, latch the frame on nCS rising.
  logic [15:0] frames[$];
  logic [15:0] dec_sr;
  int          dec_n;
  bit [7:0]    dec_reg [128];

  initial begin
    dec_n = 0; dec_sr = '0;
    forever begin
      @(posedge sclk or posedge ncs);
      if (ncs) begin
        if (rst_n && dec_n != 0) begin
          chk("frame_bitcount", 32'(dec_n), 32'd16);
          if (dec_n == 16) begin
            frames.push_back(dec_sr);
            if (dec_sr[15]) dec_reg[dec_sr[14:8]] = dec_sr[7:0];
          end
        end
        dec_n = 0;
      end else begin
        dec_sr = {dec_sr[14:0], copi};
        dec_n++;
      end
    end
  end

  // Per-cycle compare plus SPI protocol checks and nCS run-length tracking.
  int low_run = 0, high_run = 0, low_len_last = 0, gap_min = 1000, done_cnt = 0;
  bit gap_valid = 0;
  logic prev_ncs = 1'b1, prev_copi = 1'b0;

  initial begin
    int o;
    bit e_ncs, e_sclk, e_copi, e_done, e_busy, e_ready;
    forever begin
      @(negedge clk);
      e_ncs = 1; e_sclk = 0; e_copi = 0;
      if (m_active && m_off >= 1 && m_off <= LOW) begin
        o = m_off - 1;
        e_ncs = 0;
        if (o < CS_SETUP) e_copi = m_cur[15];
        else if (o < CS_SETUP + SHIFT_LEN) begin
          e_copi = m_cur[15 - (o - CS_SETUP) / (2 * CLK_DIV)];
          e_sclk = ((o - CS_SETUP) % (2 * CLK_DIV)) >= CLK_DIV;
        end
      end
      e_done  = m_active && (m_off == LOW + 1);
      e_busy  = m_active || (m_q.size() > 0);
      e_ready = m_q.size() < FIFO_DEPTH;
      chk("cycle{ncs,sclk,copi,done,err,busy,ready}",
          32'({ncs, sclk, copi, ifc.done, ifc.err, ifc.busy, ifc.req_ready}),
          32'({e_ncs, e_sclk, e_copi, e_done, m_err, e_busy, e_ready}));
      chk("sclk_while_ncs_high", 32'(ncs && sclk), 32'd0);
      chk("copi_change_while_sclk_high", 32'(sclk && (copi !== prev_copi)), 32'd0);
      if (ifc.done) done_cnt++;
      if (!ncs) begin
        if (prev_ncs && gap_valid && high_run < gap_min) gap_min = high_run;
        gap_valid = 1; high_run = 0; low_run++;
      end else begin
        if (!prev_ncs) low_len_last = low_run;
        low_run = 0; high_run++;
      end
      prev_ncs = ncs;
      prev_copi = copi;
    end
  end

  // Stimulus helpers; all called just after a falling clk edge.
  task automatic send(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    ifc.req_valid = 1'b1; ifc.req_addr = a; ifc.req_data = d;
    while (!ifc.req_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ifc.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    ifc.req_valid = 1'b0;
    while ((ifc.busy || !ncs) && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) chk(name, 32'(n), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, n;
    logic [15:0] exp5 [5];
    ifc.req_valid = 1'b0; ifc.req_addr = '0; ifc.req_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs{ncs,sclk,copi,done,err,busy,ready}",
        32'({ncs, sclk, copi, ifc.done, ifc.err, ifc.busy, ifc.req_ready}), 32'b1000001);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write
    s0 = frames.size(); d0 = done_cnt;
    send(7'd2, 8'hA5);
    wait_idle("t1_timeout");
    chk("t1_nframes", 32'(frames.size() - s0), 32'd1);
    if (frames.size() > s0) chk("t1_frame", 32'(frames[s0]), 32'h82A5);
    chk("t1_ncs_low_len", 32'(low_len_last), 32'd140);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_reg2", 32'(dec_reg[2]), 32'hA5);

    // 2: five back-to-back requests with valid held high
    s0 = frames.size(); d0 = done_cnt; gap_min = 1000;
    for (int i = 0; i < 5; i++) send(7'(i), 8'(8'h11 * (i + 1)));
    chk("t2_ready_low_when_full", 32'(ifc.req_ready), 32'd0);
    wait_idle("t2_timeout");
    exp5 = '{16'h8011, 16'h8122, 16'h8233, 16'h8344, 16'h8455};
    chk("t2_nframes", 32'(frames.size() - s0), 32'd5);
    for (int i = 0; i < 5; i++)
      if (s0 + i < frames.size()) chk("t2_frame", 32'(frames[s0 + i]), 32'(exp5[i]));
    chk("t2_min_gap_ge9", 32'(gap_min >= 9), 32'd1);
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd5);
    chk("t2_busy_low", 32'(ifc.busy), 32'd0);

    // 3: out-of-range address then a valid one
    s0 = frames.size();
    send(7'd7, 8'h77);
    ifc.req_valid = 1'b0;
    chk("t3_err_pulse", 32'(ifc.err), 32'd1);
    @(negedge clk);
    chk("t3_err_clear", 32'(ifc.err), 32'd0);
    chk("t3_no_activity{ncs,busy}", 32'({ncs, ifc.busy}), 32'b10);
    send(7'd1, 8'h3C);
    wait_idle("t3_timeout");
    chk("t3_nframes", 32'(frames.size() - s0), 32'd1);
    chk("t3_reg1", 32'(dec_reg[1]), 32'h3C);

    // 4: reset during bit 7, with a second entry still buffered
    send(7'd3, 8'h5A);
    send(7'd0, 8'h0F);
    ifc.req_valid = 1'b0;
    n = 0;
    while (dec_n < 8 && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) chk("t4_bit7_timeout", 32'(n), 32'd0);
    s0 = frames.size();
    #2 rst_n = 1'b0;
    #1 chk("t4_reset_now{ncs,sclk,copi,busy,ready}",
           32'({ncs, sclk, copi, ifc.busy, ifc.req_ready}), 32'b10001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t4_no_stale_frame", 32'(frames.size() - s0), 32'd0);
    send(7'd4, 8'h9E);
    wait_idle("t4_timeout");
    chk("t4_nframes", 32'(frames.size() - s0), 32'd1);
    if (frames.size() > s0) chk("t4_frame", 32'(frames[s0]), 32'h849E);
    chk("t4_ncs_low_len", 32'(low_len_last), 32'd140);

    // 5: push coinciding with a pop while three entries are buffered
    s0 = frames.size();
    send(7'd0, 8'hA0); send(7'd1, 8'hB1); send(7'd2, 8'hC2); send(7'd3, 8'hD3);
    ifc.req_valid = 1'b0;
    n = 0;
    while (!ifc.done && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) chk("t5_done_timeout", 32'(n), 32'd0);
    repeat (GAP_CYCLES) @(negedge clk);
    chk("t5_pre{ncs,busy,ready}", 32'({ncs, ifc.busy, ifc.req_ready}), 32'b111);
    send(7'd4, 8'hE4);
    ifc.req_valid = 1'b0;
    chk("t5_post{ncs,ready}", 32'({ncs, ifc.req_ready}), 32'b01);
    wait_idle("t5_timeout");
    exp5 = '{16'h80A0, 16'h81B1, 16'h82C2, 16'h83D3, 16'h84E4};
    chk("t5_nframes", 32'(frames.size() - s0), 32'd5);
    for (int i = 0; i < 5; i++)
      if (s0 + i < frames.size()) chk("t5_frame", 32'(frames[s0 + i]), 32'(exp5[i]));

    // Randomized traffic, including out-of-range addresses
    for (int i = 0; i < 30; i++) begin
      send(7'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(40, 320));
      else if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end
    wait_idle("rand_timeout");
    for (int a = 0; a <= MAX_ADDR; a++)
      chk("final_reg", 32'(dec_reg[a]), 32'(exp_reg[a]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
